// File: rtl/ddr2_app_fifo_if.sv
// ddr2_app_fifo_if
// Controller-side receiver of the DDR2 user application interface. Address
// and command pushes go into the address FIFO. Write-data and mask pushes go
// into the write-data FIFO. Both FIFOs are first-word-fall-through toward
// the controller core. A write command is held back until its full burst of
// data words is resident; a credit counter tracks how many words remain
// unclaimed by write commands.
module ddr2_app_fifo_if #(
    parameter int DQ_WIDTH         = 16,
    parameter int DM_WIDTH         = 2,
    parameter int AF_DEPTH         = 16,
    parameter int WDF_DEPTH        = 64,
    parameter int AF_AFULL_THRESH  = 12,
    parameter int WDF_AFULL_THRESH = 48
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              burst_length_div2,
    input  logic [35:0]             app_af_addr,
    input  logic                    app_af_wren,
    input  logic [2*DQ_WIDTH-1:0]   app_wdf_data,
    input  logic [2*DM_WIDTH-1:0]   app_mask_data,
    input  logic                    app_wdf_wren,
    output logic                    af_almost_full,
    output logic                    wdf_almost_full,
    output logic                    ctrl_cmd_valid,
    output logic [2:0]              ctrl_cmd,
    output logic [32:0]             ctrl_addr,
    input  logic                    ctrl_cmd_ack,
    output logic                    ctrl_wdf_empty,
    output logic [2*DQ_WIDTH-1:0]   ctrl_wdf_data,
    output logic [2*DM_WIDTH-1:0]   ctrl_wdf_mask,
    input  logic                    ctrl_wdf_rden,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int DW      = 2 * DQ_WIDTH;
    localparam int MW      = 2 * DM_WIDTH;
    localparam int WW      = DW + MW;
    localparam int AF_AW   = $clog2(AF_DEPTH);
    localparam int WDF_AW  = $clog2(WDF_DEPTH);
    localparam int AF_CW   = AF_AW + 1;
    localparam int WDF_CW  = WDF_AW + 1;

    localparam logic [2:0]        CMD_WRITE     = 3'b000;
    localparam logic [AF_CW-1:0]  AF_FULL_CNT   = AF_CW'(AF_DEPTH);
    localparam logic [WDF_CW-1:0] WDF_FULL_CNT  = WDF_CW'(WDF_DEPTH);
    localparam logic [AF_CW-1:0]  AF_THRESH     = AF_CW'(AF_AFULL_THRESH);
    localparam logic [WDF_CW-1:0] WDF_THRESH    = WDF_CW'(WDF_AFULL_THRESH);

    // Storage arrays (contents are meaningless while the matching count is 0)
    logic [35:0]       r_af_mem  [AF_DEPTH];
    logic [WW-1:0]     r_wdf_mem [WDF_DEPTH];

    logic [AF_AW-1:0]  r_af_wr_ptr;
    logic [AF_AW-1:0]  r_af_rd_ptr;
    logic [AF_CW-1:0]  r_af_count;
    logic [WDF_AW-1:0] r_wdf_wr_ptr;
    logic [WDF_AW-1:0] r_wdf_rd_ptr;
    logic [WDF_CW-1:0] r_wdf_count;
    logic [WDF_CW-1:0] r_credit;
    logic              r_af_afull;
    logic              r_wdf_afull;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_af_empty;
    logic              w_af_full;
    logic              w_wdf_empty;
    logic              w_wdf_full;
    logic [35:0]       w_af_head;
    logic [WW-1:0]     w_wdf_head;
    logic [2:0]        w_head_cmd;
    logic              w_head_is_write;
    logic [WDF_CW-1:0] w_bl;
    logic              w_cmd_valid;
    logic              w_af_pop;
    logic              w_af_push;
    logic              w_wdf_pop;
    logic              w_wdf_push;
    logic [AF_CW-1:0]  w_af_count_nxt;
    logic [WDF_CW-1:0] w_wdf_count_nxt;
    logic [WDF_CW-1:0] w_credit_nxt;
    logic              w_overflow_evt;
    logic              w_underflow_evt;

    // Head decode, write gating and accept/pop qualification
    always_comb begin
        w_af_empty      = (r_af_count == {AF_CW{1'b0}});
        w_af_full       = (r_af_count == AF_FULL_CNT);
        w_wdf_empty     = (r_wdf_count == {WDF_CW{1'b0}});
        w_wdf_full      = (r_wdf_count == WDF_FULL_CNT);
        w_af_head       = r_af_mem[r_af_rd_ptr];
        w_wdf_head      = r_wdf_mem[r_wdf_rd_ptr];
        w_head_cmd      = w_af_head[34:32];
        w_head_is_write = (w_head_cmd == CMD_WRITE);
        w_bl            = WDF_CW'(burst_length_div2);
        // A write command is only presented once its burst is resident; a
        // zero burst length makes the comparison always true (ungated).
        if (w_head_is_write) begin
            w_cmd_valid = !w_af_empty && (r_credit >= w_bl);
        end else begin
            w_cmd_valid = !w_af_empty;
        end
        w_af_pop   = ctrl_cmd_ack && w_cmd_valid;
        w_wdf_pop  = ctrl_wdf_rden && !w_wdf_empty;
        // A push on a full FIFO is still taken when the same cycle pops a slot
        w_af_push  = app_af_wren && (!w_af_full || w_af_pop);
        w_wdf_push = app_wdf_wren && (!w_wdf_full || w_wdf_pop);
        w_overflow_evt  = (app_af_wren && !w_af_push) || (app_wdf_wren && !w_wdf_push);
        w_underflow_evt = (ctrl_cmd_ack && !w_cmd_valid) || (ctrl_wdf_rden && w_wdf_empty);
    end

    // Next-state occupancy of both FIFOs
    always_comb begin
        w_af_count_nxt  = r_af_count;
        w_wdf_count_nxt = r_wdf_count;
        case ({w_af_push, w_af_pop})
            2'b10:   w_af_count_nxt = r_af_count + AF_CW'(1);
            2'b01:   w_af_count_nxt = r_af_count - AF_CW'(1);
            default: w_af_count_nxt = r_af_count;
        endcase
        case ({w_wdf_push, w_wdf_pop})
            2'b10:   w_wdf_count_nxt = r_wdf_count + WDF_CW'(1);
            2'b01:   w_wdf_count_nxt = r_wdf_count - WDF_CW'(1);
            default: w_wdf_count_nxt = r_wdf_count;
        endcase
    end

    // Next-state write credit: +1 per accepted word, -burst per write issued
    always_comb begin
        w_credit_nxt = r_credit;
        if (w_wdf_push) begin
            w_credit_nxt = w_credit_nxt + WDF_CW'(1);
        end else begin
            w_credit_nxt = w_credit_nxt;
        end
        if (w_af_pop && w_head_is_write) begin
            w_credit_nxt = w_credit_nxt - w_bl;
        end else begin
            w_credit_nxt = w_credit_nxt;
        end
    end

    // Storage writes; arrays are not reset because counts qualify every read
    always_ff @(posedge clk) begin
        if (w_af_push) begin
            r_af_mem[r_af_wr_ptr] <= app_af_addr;
        end
        if (w_wdf_push) begin
            r_wdf_mem[r_wdf_wr_ptr] <= {app_mask_data, app_wdf_data};
        end
    end

    // Address FIFO pointers and count (pointers wrap at the power-of-2 depth)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_af_wr_ptr <= {AF_AW{1'b0}};
            r_af_rd_ptr <= {AF_AW{1'b0}};
            r_af_count  <= {AF_CW{1'b0}};
        end else begin
            if (w_af_push) begin
                r_af_wr_ptr <= r_af_wr_ptr + AF_AW'(1);
            end
            if (w_af_pop) begin
                r_af_rd_ptr <= r_af_rd_ptr + AF_AW'(1);
            end
            r_af_count <= w_af_count_nxt;
        end
    end

    // Write-data FIFO pointers, count and write credit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdf_wr_ptr <= {WDF_AW{1'b0}};
            r_wdf_rd_ptr <= {WDF_AW{1'b0}};
            r_wdf_count  <= {WDF_CW{1'b0}};
            r_credit     <= {WDF_CW{1'b0}};
        end else begin
            if (w_wdf_push) begin
                r_wdf_wr_ptr <= r_wdf_wr_ptr + WDF_AW'(1);
            end
            if (w_wdf_pop) begin
                r_wdf_rd_ptr <= r_wdf_rd_ptr + WDF_AW'(1);
            end
            r_wdf_count <= w_wdf_count_nxt;
            r_credit    <= w_credit_nxt;
        end
    end

    // Registered back-pressure and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_af_afull  <= 1'b0;
            r_wdf_afull <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_af_afull  <= (w_af_count_nxt >= AF_THRESH);
            r_wdf_afull <= (w_wdf_count_nxt >= WDF_THRESH);
            r_overflow  <= r_overflow | w_overflow_evt;
            r_underflow <= r_underflow | w_underflow_evt;
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks
    always_comb begin
        af_almost_full  = r_af_afull;
        wdf_almost_full = r_wdf_afull;
        ctrl_cmd_valid  = w_cmd_valid;
        ctrl_wdf_empty  = w_wdf_empty;
        overflow_err    = r_overflow;
        underflow_err   = r_underflow;
        if (w_af_empty) begin
            ctrl_cmd  = 3'b000;
            ctrl_addr = 33'd0;
        end else begin
            ctrl_cmd  = w_head_cmd;
            ctrl_addr = {w_af_head[35], w_af_head[31:0]};
        end
        if (w_wdf_empty) begin
            ctrl_wdf_data = {DW{1'b0}};
            ctrl_wdf_mask = {MW{1'b0}};
        end else begin
            ctrl_wdf_data = w_wdf_head[DW-1:0];
            ctrl_wdf_mask = w_wdf_head[WW-1:DW];
        end
    end

endmodule

// File: tb/tb_ddr2_app_fifo_if.sv
// Bench for ddr2_app_fifo_if: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_ddr2_app_fifo_if;

    localparam int AF_DEPTH   = 16;
    localparam int WDF_DEPTH  = 64;
    localparam int AF_THRESH  = 12;
    localparam int WDF_THRESH = 48;

    logic        clk;
    logic        reset_n;
    logic [2:0]  burst_length_div2;
    logic [35:0] app_af_addr;
    logic        app_af_wren;
    logic [31:0] app_wdf_data;
    logic [3:0]  app_mask_data;
    logic        app_wdf_wren;
    logic        af_almost_full;
    logic        wdf_almost_full;
    logic        ctrl_cmd_valid;
    logic [2:0]  ctrl_cmd;
    logic [32:0] ctrl_addr;
    logic        ctrl_cmd_ack;
    logic        ctrl_wdf_empty;
    logic [31:0] ctrl_wdf_data;
    logic [3:0]  ctrl_wdf_mask;
    logic        ctrl_wdf_rden;
    logic        overflow_err;
    logic        underflow_err;

    ddr2_app_fifo_if dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .burst_length_div2 (burst_length_div2),
        .app_af_addr       (app_af_addr),
        .app_af_wren       (app_af_wren),
        .app_wdf_data      (app_wdf_data),
        .app_mask_data     (app_mask_data),
        .app_wdf_wren      (app_wdf_wren),
        .af_almost_full    (af_almost_full),
        .wdf_almost_full   (wdf_almost_full),
        .ctrl_cmd_valid    (ctrl_cmd_valid),
        .ctrl_cmd          (ctrl_cmd),
        .ctrl_addr         (ctrl_addr),
        .ctrl_cmd_ack      (ctrl_cmd_ack),
        .ctrl_wdf_empty    (ctrl_wdf_empty),
        .ctrl_wdf_data     (ctrl_wdf_data),
        .ctrl_wdf_mask     (ctrl_wdf_mask),
        .ctrl_wdf_rden     (ctrl_wdf_rden),
        .overflow_err      (overflow_err),
        .underflow_err     (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [35:0] m_af_q[$];
    logic [35:0] m_wdf_q[$];   // {mask, data}
    int          m_credit;
    int          m_bl;
    bit          m_over;
    bit          m_under;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_cmd_valid();
        if (m_af_q.size() == 0) return 1'b0;
        if (m_af_q[0][34:32] == 3'b000) return (m_credit >= m_bl);
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check_val("af_almost_full", 64'(af_almost_full), 64'(m_af_q.size() >= AF_THRESH));
        check_val("wdf_almost_full", 64'(wdf_almost_full), 64'(m_wdf_q.size() >= WDF_THRESH));
        check_val("cmd_valid", 64'(ctrl_cmd_valid), 64'(model_cmd_valid()));
        check_val("wdf_empty", 64'(ctrl_wdf_empty), 64'(m_wdf_q.size() == 0));
        check_val("overflow_err", 64'(overflow_err), 64'(m_over));
        check_val("underflow_err", 64'(underflow_err), 64'(m_under));
        if (m_af_q.size() > 0) begin
            check_val("ctrl_cmd", 64'(ctrl_cmd), 64'(m_af_q[0][34:32]));
            check_val("ctrl_addr", 64'(ctrl_addr), 64'({m_af_q[0][35], m_af_q[0][31:0]}));
        end
        if (m_wdf_q.size() > 0) begin
            check_val("wdf_data", 64'(ctrl_wdf_data), 64'(m_wdf_q[0][31:0]));
            check_val("wdf_mask", 64'(ctrl_wdf_mask), 64'(m_wdf_q[0][35:32]));
        end
    endtask

    // One clock of traffic: drive, let the edge happen, advance model, compare
    task automatic step(input logic aw, input logic [35:0] addr, input logic ww,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic ack, input logic rd);
        bit valid, ack_ok, rd_ok, af_ok, wdf_ok, is_wr;
        app_af_wren   = aw;
        app_af_addr   = addr;
        app_wdf_wren  = ww;
        app_wdf_data  = d;
        app_mask_data = m;
        ctrl_cmd_ack  = ack;
        ctrl_wdf_rden = rd;
        valid  = model_cmd_valid();
        ack_ok = ack && valid;
        rd_ok  = rd && (m_wdf_q.size() > 0);
        af_ok  = aw && ((m_af_q.size() < AF_DEPTH) || ack_ok);
        wdf_ok = ww && ((m_wdf_q.size() < WDF_DEPTH) || rd_ok);
        is_wr  = (m_af_q.size() > 0) && (m_af_q[0][34:32] == 3'b000);
        @(posedge clk);
        #1;
        if (ack && !valid) m_under = 1'b1;
        if (rd && !rd_ok) m_under = 1'b1;
        if ((aw && !af_ok) || (ww && !wdf_ok)) m_over = 1'b1;
        if (ack_ok) begin
            void'(m_af_q.pop_front());
            if (is_wr) m_credit -= m_bl;
        end
        if (rd_ok) void'(m_wdf_q.pop_front());
        if (af_ok) m_af_q.push_back(addr);
        if (wdf_ok) begin
            m_wdf_q.push_back({m, d});
            m_credit += 1;
        end
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, confirm the flushed state, release on a falling edge
    task automatic do_reset(input logic [2:0] bl);
        reset_n = 1'b0;
        #1;
        m_af_q.delete();
        m_wdf_q.delete();
        m_credit = 0;
        m_over   = 1'b0;
        m_under  = 1'b0;
        m_bl     = int'(bl);
        check_val("rst_af_afull", 64'(af_almost_full), 64'd0);
        check_val("rst_wdf_afull", 64'(wdf_almost_full), 64'd0);
        check_val("rst_cmd_valid", 64'(ctrl_cmd_valid), 64'd0);
        check_val("rst_cmd", 64'(ctrl_cmd), 64'd0);
        check_val("rst_addr", 64'(ctrl_addr), 64'd0);
        check_val("rst_wdf_empty", 64'(ctrl_wdf_empty), 64'd1);
        check_val("rst_wdf_data", 64'(ctrl_wdf_data), 64'd0);
        check_val("rst_wdf_mask", 64'(ctrl_wdf_mask), 64'd0);
        check_val("rst_overflow", 64'(overflow_err), 64'd0);
        check_val("rst_underflow", 64'(underflow_err), 64'd0);
        burst_length_div2 = bl;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [35:0] mk_addr(input logic [2:0] cmd, input logic [31:0] a);
        return {1'($urandom % 2), cmd, a};
    endfunction

    initial begin
        logic [35:0] a;
        logic [2:0]  c;
        int          r;
        reset_n           = 1'b0;
        burst_length_div2 = 3'd2;
        app_af_addr       = 36'd0;
        app_af_wren       = 1'b0;
        app_wdf_data      = 32'd0;
        app_mask_data     = 4'd0;
        app_wdf_wren      = 1'b0;
        ctrl_cmd_ack      = 1'b0;
        ctrl_wdf_rden     = 1'b0;

        // Reset with a push held: first push lands one cycle after release
        a = 36'h9_1234_5678;
        app_af_wren = 1'b1;
        app_af_addr = a;
        do_reset(3'd2);
        step(1'b1, a, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

        // Write gated until two words (bl=2) are resident
        do_reset(3'd2);
        step(1'b1, {1'b0, 3'b000, 32'h100}, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b1, 32'hA5A5_0001, 4'h3, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b1, 32'h5A5A_0002, 4'hC, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        idle();

        // Address FIFO almost-full, deassert, fill, overflow, drain, underflow
        for (int i = 0; i < AF_THRESH; i++)
            step(1'b1, mk_addr(3'b001, 32'h2000 + 32'(i)), 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, mk_addr(3'(2 + (i % 6)), 32'h3000 + 32'(i)), 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < AF_DEPTH + 1; i++)
            step(1'b0, 36'd0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

        // Simultaneous push + write ack with bl=4; full WDF push+pop
        do_reset(3'd4);
        for (int i = 0; i < 4; i++)
            step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b0);
        step(1'b1, {1'b1, 3'b000, 32'h4000}, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b1, 1'b0);
        step(1'b1, {1'b0, 3'b000, 32'h4004}, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < WDF_DEPTH - 5; i++)
            step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b1);
        step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b0);

        // Reset mid-burst with 3 commands and 10 words buffered
        do_reset(3'd4);
        for (int i = 0; i < 3; i++)
            step(1'b1, mk_addr(3'b000, 32'h5000 + 32'(i * 16)), 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 36'd0, 1'b1, 32'($urandom), 4'($urandom), 1'b0, 1'b0);
        do_reset(3'd4);
        idle();
        idle();

        // Randomized traffic in several reset epochs
        for (int epoch = 0; epoch < 4; epoch++) begin
            do_reset(((epoch % 2) == 0) ? 3'd2 : 3'd4);
            for (int n = 0; n < 300; n++) begin
                r = int'($urandom % 8);
                c = (r < 5) ? 3'b000 : ((r < 7) ? 3'b001 : 3'($urandom));
                step(1'(($urandom % 100) < 45), mk_addr(c, 32'($urandom)),
                     1'(($urandom % 100) < 55), 32'($urandom), 4'($urandom),
                     1'(($urandom % 100) < 40),
                     (m_wdf_q.size() > 0) ? 1'(($urandom % 100) < 45) : 1'(($urandom % 100) < 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
